// File: rtl/fft_readout_ctrl_if.sv
// RAM read port and output beat stream of the FFT readout controller.
interface fft_readout_ctrl_if #(parameter int DW = 16);
   logic          ram_re;
   logic [3:0]    ram_addr;
   logic [DW-1:0] ram_data_r;
   logic [DW-1:0] ram_data_i;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data_r;
   logic [DW-1:0] out_data_i;
   logic [3:0]    out_index;
   logic          out_last;

   modport master (
      output ram_re, ram_addr, out_valid, out_data_r, out_data_i, out_index, out_last,
      input  ram_data_r, ram_data_i, out_ready
   );

   modport slave (
      input  ram_re, ram_addr, out_valid, out_data_r, out_data_i, out_index, out_last,
      output ram_data_r, ram_data_i, out_ready
   );
endinterface

// File: rtl/fft_readout_ctrl.sv
// Streams the 16 FFT result bins out of the result RAM, optionally undoing bit-reversed order.
// First beat 3 cycles after start; reads throttle so at most 2 run ahead of the displayed beat.
module fft_readout_ctrl #(
   parameter int DW      = 16,
   parameter bit BIT_REV = 1'b1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   output logic               busy,
   output logic               fft_hold,
   output logic               done,
   fft_readout_ctrl_if.master bus
);
   typedef enum logic [1:0] {IDLE, SETTLE, READ, DRAIN} state_t;
   state_t state, state_nxt;

   logic [3:0]    iss;
   logic [3:0]    in_idx;
   logic          rd_pend;
   logic [DW-1:0] fifo_r [2];
   logic [DW-1:0] fifo_i [2];
   logic [3:0]    fifo_x [2];
   logic          wr_ptr, rd_ptr;
   logic [1:0]    fifo_cnt;
   logic          pop, head_free, fifo_pop, fifo_push, load_in, room;
   logic          issue, frame_start, frame_end;
   logic [2:0]    live;

   function automatic logic [3:0] bitrev4(input logic [3:0] k);
      return {k[0], k[1], k[2], k[3]};
   endfunction

   assign pop       = bus.out_valid && bus.out_ready;
   assign head_free = !bus.out_valid || pop;
   assign fifo_pop  = head_free && (fifo_cnt != 2'd0);
   assign load_in   = head_free && (fifo_cnt == 2'd0) && rd_pend;
   assign fifo_push = rd_pend && !load_in;
   // Every beat still owed to the stream: head, buffered, and both RAM pipeline stages.
   assign live      = 3'(bus.out_valid) + 3'(fifo_cnt) + 3'(rd_pend) + 3'(bus.ram_re);
   assign room      = live < (3'd3 + 3'(pop));
   assign fft_hold  = busy;

   always_comb begin
      state_nxt   = state;
      issue       = 1'b0;
      frame_start = 1'b0;
      frame_end   = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt   = SETTLE;
               frame_start = 1'b1;
            end
         end
         SETTLE: begin
            issue     = room;
            state_nxt = READ;
         end
         READ: begin
            issue = room;
            if (room && iss == 4'd15) state_nxt = DRAIN;
         end
         DRAIN: begin
            if (pop && bus.out_last) begin
               state_nxt = IDLE;
               frame_end = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         busy           <= 1'b0;
         done           <= 1'b0;
         iss            <= 4'd0;
         in_idx         <= 4'd0;
         rd_pend        <= 1'b0;
         wr_ptr         <= 1'b0;
         rd_ptr         <= 1'b0;
         fifo_cnt       <= 2'd0;
         bus.ram_re     <= 1'b0;
         bus.ram_addr   <= 4'd0;
         bus.out_valid  <= 1'b0;
         bus.out_last   <= 1'b0;
         bus.out_index  <= 4'd0;
         bus.out_data_r <= '0;
         bus.out_data_i <= '0;
      end else begin
         state <= state_nxt;
         done  <= frame_end;
         if (frame_start) begin
            busy   <= 1'b1;
            iss    <= 4'd0;
            in_idx <= 4'd0;
         end else if (frame_end) begin
            busy <= 1'b0;
         end
         bus.ram_re <= issue;
         if (issue) begin
            bus.ram_addr <= BIT_REV ? bitrev4(iss) : iss;
            iss          <= iss + 4'd1;
         end
         rd_pend <= bus.ram_re;
         if (rd_pend) in_idx <= in_idx + 4'd1;
         if (fifo_push) wr_ptr <= ~wr_ptr;
         if (fifo_pop) rd_ptr <= ~rd_ptr;
         fifo_cnt <= fifo_cnt + 2'(fifo_push) - 2'(fifo_pop);
         if (fifo_pop) begin
            bus.out_valid  <= 1'b1;
            bus.out_data_r <= fifo_r[rd_ptr];
            bus.out_data_i <= fifo_i[rd_ptr];
            bus.out_index  <= fifo_x[rd_ptr];
            bus.out_last   <= (fifo_x[rd_ptr] == 4'd15);
         end else if (load_in) begin
            bus.out_valid  <= 1'b1;
            bus.out_data_r <= bus.ram_data_r;
            bus.out_data_i <= bus.ram_data_i;
            bus.out_index  <= in_idx;
            bus.out_last   <= (in_idx == 4'd15);
         end else if (head_free) begin
            bus.out_valid <= 1'b0;
            bus.out_last  <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (fifo_push) begin
         fifo_r[wr_ptr] <= bus.ram_data_r;
         fifo_i[wr_ptr] <= bus.ram_data_i;
         fifo_x[wr_ptr] <= in_idx;
      end
   end
endmodule

// File: tb/tb_fft_readout_ctrl.sv
// Scoreboard bench: one natural-order and one bit-reversed instance, each fed by a
// registered RAM model holding r=0x1000+a, i=0x2000+a.
module tb_fft_readout_ctrl;
   typedef struct packed { logic [15:0] r; logic [15:0] i; logic [3:0] idx; } beat_t;

   logic clk    = 1'b0;
   logic rst_n  = 1'b0;
   logic start0 = 1'b0;
   logic start1 = 1'b0;
   logic busy0, hold0, done0, busy1, hold1, done1;

   int    checks = 0;
   int    fails  = 0;
   beat_t q0[$];
   beat_t q1[$];
   int    iss[2], acc[2], beats[2], dones[2], hs_idx[2];
   bit    exp_done[2], prev_stall[2];
   beat_t prev_head[2];
   bit    tog_en = 1'b0;
   logic [15:0] pat = 16'b1001_1000_1101_0011;

   fft_readout_ctrl_if #(.DW(16)) b0 ();
   fft_readout_ctrl_if #(.DW(16)) b1 ();

   fft_readout_ctrl #(.DW(16), .BIT_REV(1'b0)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start0), .busy(busy0),
      .fft_hold(hold0), .done(done0), .bus(b0.master)
   );
   fft_readout_ctrl #(.DW(16), .BIT_REV(1'b1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1),
      .fft_hold(hold1), .done(done1), .bus(b1.master)
   );

   always #5 clk = ~clk;

   // Registered-read RAM; junk on the data bus whenever no read was issued.
   always @(posedge clk) begin
      b0.ram_data_r <= b0.ram_re ? 16'h1000 + {12'h0, b0.ram_addr} : 16'hDEAD;
      b0.ram_data_i <= b0.ram_re ? 16'h2000 + {12'h0, b0.ram_addr} : 16'hBEEF;
      b1.ram_data_r <= b1.ram_re ? 16'h1000 + {12'h0, b1.ram_addr} : 16'hDEAD;
      b1.ram_data_i <= b1.ram_re ? 16'h2000 + {12'h0, b1.ram_addr} : 16'hBEEF;
   end

   initial begin
      int p = 0;
      b0.out_ready = 1'b1;
      b1.out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         b0.out_ready = tog_en ? pat[p] : 1'b1;
         if (tog_en) p = (p + 1) % 16;
      end
   end

   function automatic logic [3:0] bitrev(input logic [3:0] k);
      return {k[0], k[1], k[2], k[3]};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic bit pop_exp(input int d, output beat_t e);
      e = '0;
      if (d == 0) begin
         if (q0.size() == 0) return 1'b0;
         e = q0.pop_front();
      end else begin
         if (q1.size() == 0) return 1'b0;
         e = q1.pop_front();
      end
      return 1'b1;
   endfunction

   task automatic mon(input int d, input logic vld, input logic rdy, input logic re,
                      input logic [3:0] addr, input logic [3:0] idx, input logic last,
                      input logic [15:0] dr, input logic [15:0] di,
                      input logic dn, input logic bsy);
      beat_t h, e;
      h = {dr, di, idx};
      if (dn || exp_done[d]) begin
         check($sformatf("done%0d", d), dn, exp_done[d]);
         if (exp_done[d]) check($sformatf("busy%0d_with_done", d), bsy, 0);
      end
      if (dn) dones[d]++;
      exp_done[d] = 1'b0;
      if (re) begin
         check($sformatf("ram_addr%0d", d), addr, (d == 1) ? bitrev(4'(iss[d])) : 4'(iss[d]));
         iss[d]++;
         check($sformatf("reads_ahead%0d", d), (iss[d] - acc[d] - int'(vld)) <= 2, 1);
      end
      if (prev_stall[d]) check($sformatf("stall_hold%0d", d), {vld, h}, {1'b1, prev_head[d]});
      if (vld && rdy) begin
         if (!pop_exp(d, e)) begin
            checks++;
            fails++;
            $display("FAIL beat%0d_unexpected: got bin %0d, expected no beat", d, idx);
         end else begin
            check($sformatf("data_r%0d_bin%0d", d, e.idx), dr, e.r);
            check($sformatf("data_i%0d_bin%0d", d, e.idx), di, e.i);
            check($sformatf("index%0d", d), idx, e.idx);
            check($sformatf("last%0d_bin%0d", d, e.idx), last, e.idx == 4'd15);
         end
         acc[d]++;
         beats[d]++;
         hs_idx[d] = int'(idx);
         if (idx == 4'd15) exp_done[d] = 1'b1;
      end
      prev_stall[d] = vld && !rdy;
      prev_head[d]  = h;
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         mon(0, b0.out_valid, b0.out_ready, b0.ram_re, b0.ram_addr, b0.out_index, b0.out_last,
             b0.out_data_r, b0.out_data_i, done0, busy0);
         mon(1, b1.out_valid, b1.out_ready, b1.ram_re, b1.ram_addr, b1.out_index, b1.out_last,
             b1.out_data_r, b1.out_data_i, done1, busy1);
      end
   end

   task automatic start_frame(input int d);
      beat_t e;
      int lat;
      for (int k = 0; k < 16; k++) begin
         e.idx = 4'(k);
         e.r   = 16'h1000 + {12'h0, (d == 1) ? bitrev(4'(k)) : 4'(k)};
         e.i   = 16'h2000 + {12'h0, (d == 1) ? bitrev(4'(k)) : 4'(k)};
         if (d == 0) q0.push_back(e); else q1.push_back(e);
      end
      iss[d]    = 0;
      acc[d]    = 0;
      beats[d]  = 0;
      hs_idx[d] = -1;
      if (d == 0) start0 = 1'b1; else start1 = 1'b1;
      @(posedge clk);
      #1;
      start0 = 1'b0;
      start1 = 1'b0;
      check($sformatf("busy%0d_rise", d), (d == 0) ? busy0 : busy1, 1);
      check($sformatf("fft_hold%0d_rise", d), (d == 0) ? hold0 : hold1, 1);
      lat = 0;
      for (int c = 1; c <= 8 && lat == 0; c++) begin
         @(posedge clk);
         #1;
         if ((d == 0) ? b0.out_valid : b1.out_valid) lat = c;
      end
      check($sformatf("latency%0d", d), lat, 3);
   endtask

   task automatic wait_done(input int d);
      bit got = 1'b0;
      for (int c = 0; c < 300 && !got; c++) begin
         @(negedge clk);
         if ((d == 0) ? done0 : done1) got = 1'b1;
      end
      check($sformatf("done%0d_seen", d), got, 1);
      check($sformatf("beats%0d", d), beats[d], 16);
      check($sformatf("queue%0d_empty", d), (d == 0) ? q0.size() : q1.size(), 0);
   endtask

   task automatic wait_bin(input int d, input int k);
      for (int c = 0; c < 300 && hs_idx[d] != k; c++) @(negedge clk);
      check($sformatf("reached_bin%0d", k), hs_idx[d], k);
   endtask

   task automatic chk_reset(input string tag);
      check({tag, "_busy"}, busy0, 0);
      check({tag, "_fft_hold"}, hold0, 0);
      check({tag, "_done"}, done0, 0);
      check({tag, "_ram_re"}, b0.ram_re, 0);
      check({tag, "_ram_addr"}, b0.ram_addr, 0);
      check({tag, "_out_valid"}, b0.out_valid, 0);
      check({tag, "_out_last"}, b0.out_last, 0);
      check({tag, "_out_index"}, b0.out_index, 0);
      check({tag, "_out_data"}, {b0.out_data_r, b0.out_data_i}, 0);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk_reset("reset");
      check("reset_busy1", busy1, 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      start_frame(0);
      wait_done(0);

      @(posedge clk);
      #1;
      start_frame(1);
      wait_done(1);

      @(posedge clk);
      #1;
      tog_en = 1'b1;
      start_frame(0);
      wait_done(0);
      tog_en = 1'b0;

      // start during the frame must be ignored
      @(posedge clk);
      #1;
      start_frame(0);
      wait_bin(0, 5);
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      wait_done(0);
      repeat (4) @(negedge clk);
      check("busy0_idle_after_ignored_start", busy0, 0);
      check("dones0_after_ignored_start", dones[0], 3);

      // reset in the middle of a frame
      @(posedge clk);
      #1;
      start_frame(0);
      wait_bin(0, 7);
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset("midreset");
      q0.delete();
      exp_done[0]   = 1'b0;
      prev_stall[0] = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      start_frame(0);
      wait_done(0);

      // back-to-back: second start in the done cycle
      @(posedge clk);
      #1;
      start_frame(0);
      wait_done(0);
      check("busy0_low_in_done_cycle", busy0, 0);
      start_frame(0);
      wait_done(0);

      repeat (3) @(negedge clk);
      check("dones0_total", dones[0], 6);
      check("dones1_total", dones[1], 1);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule

// File: doc/fft_readout_ctrl.md
# fft_readout_ctrl

Sequences readout of the 16-point FFT result RAM (`slave_ram`) into a valid/ready output stream. On a frame-start pulse it holds the upstream FFT outputs stable, issues 16 registered reads, optionally undoes bit-reversed ordering, and absorbs downstream backpressure without losing or duplicating samples. It sits between the FFT core/result RAM and the output interface (host/DMA side).

## Interface
Parameters:
- `DW`, 16, real/imag sample width; must match the RAM data width.
- `BIT_REV`, 1, 1: output index k reads RAM address bitrev4(k); 0: address = k.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse: FFT result is valid on the RAM inputs; begin a frame.
- `busy`  out  1  high from the accepted `start` until the final beat's handshake.
- `fft_hold`  out  1  upstream FFT must keep its 32 outputs stable while high; equals `busy`.
- `ram_re`  out  1  RAM read enable.
- `ram_addr`  out  4  RAM read address.
- `ram_data_r`  in  DW  RAM `data_r`; valid the cycle after `ram_re`.
- `ram_data_i`  in  DW  RAM `data_i`; valid the cycle after `ram_re`.
- `out_valid`  out  1  output beat valid.
- `out_ready`  in  1  downstream accepts the beat when `out_valid && out_ready`.
- `out_data_r`  out  DW  real part.
- `out_data_i`  out  DW  imaginary part.
- `out_index`  out  4  frequency bin 0..15 of the current beat.
- `out_last`  out  1  high with bin 15.
- `done`  out  1  one-cycle pulse after the bin-15 handshake.

## Operation
- All outputs are registered. Reset values: `busy`, `fft_hold`, `ram_re`, `out_valid`, `out_last`, `done` = 0; `ram_addr`, `out_index`, `out_data_r`, `out_data_i` = 0.
- FSM states IDLE, SETTLE, READ, DRAIN.
  - IDLE: `start`=1 -> SETTLE; set `busy`/`fft_hold`; clear issue counter `iss` and output counter.
  - SETTLE: one cycle, lets the RAM capture the held FFT outputs -> READ.
  - READ: issues a read (`ram_re`=1, `ram_addr` = BIT_REV ? bitrev4(iss) : iss, `iss`++) only when buffer occupancy + reads in flight < 2; after the read for `iss`=15 -> DRAIN.
  - DRAIN: waits for the bin-15 handshake -> IDLE; clears `busy`/`fft_hold`, pulses `done`.
- Output buffer: 2-entry FIFO of {data_r, data_i, index}; written the cycle after each issued read from `ram_data_r`/`ram_data_i`; head drives `out_*`. RAM data is ignored in cycles with no read in flight.
- `out_index` increments 0..15 in order; `out_last` = (`out_index`==15) && `out_valid`.
- `start` while `busy` is ignored; it is neither queued nor restarts the frame.
- `out_valid` is never retracted and the head beat never changes until a handshake occurs.
- `rst_n` low mid-frame: immediate return to reset values; the partial frame is discarded; no `done`.

## Timing
- Edge E0 samples `start`; SETTLE is the cycle after E0; first `ram_re`=1 after E1; RAM data valid after E2; first `out_valid`=1 after E3 (3-cycle start-to-first-beat latency).
- With `out_ready` held high: one beat per cycle, bins 0..15 on 16 consecutive cycles; `done` the cycle after bin 15; `busy` falls with `done`.
- `out_ready` low: at most 2 reads outstanding/buffered; reads stop until space frees; resume the cycle after a handshake frees space.
- Back-to-back frames: `start` is accepted no earlier than the cycle `busy` is low (the `done` cycle).

## Test plan
- RAM preloaded with r=0x1000+a, i=0x2000+a at address a; BIT_REV=0; `out_ready`=1; pulse `start` -> `out_valid` 3 cycles later, bins 0..15 with r=0x1000..0x100F, `out_last` on bin 15, `done` once, `busy` low afterward.
- Same preload, BIT_REV=1 -> bin k carries r=0x1000+bitrev4(k) (bin 1 = 0x1008, bin 3 = 0x100C); `ram_addr` sequence 0,8,4,12,...
- `out_ready` toggling 1,0,0,1 pseudo-randomly -> exactly 16 beats, in order, no duplicates; head stable while stalled; never more than 2 reads ahead.
- `start` pulsed again at bin 5 -> ignored; frame completes normally; only one `done`.
- `rst_n` asserted at bin 7 -> all outputs return to reset values asynchronously; new `start` after release yields a full 0..15 frame.
- Two frames back-to-back with `start` in the `done` cycle -> second frame begins cleanly, bins 0..15 again.
